// File: rtl/cpu_pkg.sv
// Shared CPU definitions: word width, halt opcode default and fetch-state encoding.
package cpu_pkg;
    localparam int         WORD_W          = 16;
    localparam logic [3:0] HALT_OP_DEFAULT = 4'hF;

    typedef enum logic [1:0] {
        FETCH,
        DRAIN,
        HALTED
    } fetch_state_e;
endpackage

// File: rtl/instr_fifo.sv
// Circular instruction queue. Flush clears all entries; pushes when full and pops when empty are ignored.
module instr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [WIDTH-1:0]         head_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    assign do_push = push_i && !flush_i && (count_q != CNT_W'(DEPTH));
    assign do_pop  = pop_i  && !flush_i && (count_q != '0);

    // NOTE: storage has no reset; the count alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];
endmodule

// File: rtl/fetch_buffer.sv
// Instruction fetch front end: sequential PC, prefetch queue, redirect flush and halt sequencing.
module fetch_buffer
    import cpu_pkg::*;
#(
    parameter int         DEPTH   = 4,
    parameter logic [3:0] HALT_OP = HALT_OP_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [WORD_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [WORD_W-1:0] imem_rdata,
    input  logic              redirect,
    input  logic [WORD_W-1:0] redirect_pc,
    input  logic              id_ready,
    output logic              instr_valid,
    output logic [WORD_W-1:0] instr,
    output logic [WORD_W-1:0] instr_pc,
    output logic              hlt
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    fetch_state_e        state_q, state_d;
    logic [WORD_W-1:0]   fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0]    count;
    logic [2*WORD_W-1:0] head;
    logic                live, flush, req_raw, push, pop, head_is_halt;

    assign live    = (state_q != HALTED);
    assign flush   = redirect && live;
    assign req_raw = (state_q == FETCH) && (count < CNT_W'(DEPTH)) && !redirect;
    assign push    = req_raw && imem_ack;
    assign pop     = instr_valid && id_ready && live && !redirect;

    // Output gated by reset so no request leaks out while the flops are held.
    assign imem_req  = req_raw && rst_n;
    assign imem_addr = fetch_pc_q;

    assign instr_valid  = (count != '0);
    assign instr        = head[2*WORD_W-1:WORD_W];
    assign instr_pc     = head[WORD_W-1:0];
    assign head_is_halt = (instr[WORD_W-1 -: 4] == HALT_OP);
    assign hlt          = (state_q == HALTED);

    instr_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2 * WORD_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (flush),
        .wdata_i ({imem_rdata, fetch_pc_q + WORD_W'(1)}),
        .count_o (count),
        .head_o  (head)
    );

    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        if (flush) begin
            state_d    = FETCH;
            fetch_pc_d = redirect_pc;
        end else begin
            if (push) fetch_pc_d = fetch_pc_q + WORD_W'(1);
            case (state_q)
                FETCH:   if (push && imem_rdata[WORD_W-1 -: 4] == HALT_OP) state_d = DRAIN;
                DRAIN:   if (pop && head_is_halt) state_d = HALTED;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FETCH;
            fetch_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end
endmodule

// File: tb/tb_fetch_buffer.sv
// Bench for fetch_buffer: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_fetch_buffer;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_rdata = '0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic        id_ready = 1'b0;
    logic        instr_valid;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        hlt;

    fetch_buffer #(.DEPTH(DEPTH), .HALT_OP(4'hF)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .id_ready    (id_ready),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .hlt         (hlt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: ordered list of queued {instr, pc+1}, next fetch address, and mode
    // (0 = fetching, 1 = halt fetched and draining, 2 = halted).
    typedef struct {
        logic [15:0] word;
        logic [15:0] pc1;
    } ent_t;

    ent_t        mq[$];
    logic [15:0] m_pc;
    int          m_mode;

    bit          use_rand = 1'b0;
    bit          halt_en = 1'b0;
    logic [15:0] halt_addr = '0;

    bit          o_req, o_valid, o_hlt;
    logic [15:0] o_addr, o_pc;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return (halt_en && a == halt_addr) ? 16'hF000 : {4'h1, a[11:0]};
    endfunction

    // One clock: drive at the falling edge, check combinational outputs, advance the model.
    task automatic step(input bit ack, input bit rdy, input bit redir, input logic [15:0] rpc);
        bit          e_req, e_valid;
        logic [15:0] r, nxt;
        ent_t        e;
        imem_ack    = ack;
        id_ready    = rdy;
        redirect    = redir;
        redirect_pc = rpc;
        if (use_rand) begin
            r = 16'($urandom);
            if (r[15:12] == 4'hF && $urandom_range(0, 3) != 0) r[15:12] = 4'hE;
            imem_rdata = r;
        end else begin
            imem_rdata = mem_word(m_pc);
        end
        #2;
        o_req   = imem_req;
        o_valid = instr_valid;
        o_hlt   = hlt;
        o_addr  = imem_addr;
        o_pc    = instr_pc;

        e_req   = (m_mode == 0) && (mq.size() < DEPTH) && !redir;
        e_valid = (mq.size() != 0);
        check("imem_req", 32'(o_req), 32'(e_req));
        if (e_req) check("imem_addr", 32'(o_addr), 32'(m_pc));
        check("instr_valid", 32'(o_valid), 32'(e_valid));
        if (e_valid) begin
            check("instr", 32'(instr), 32'(mq[0].word));
            check("instr_pc", 32'(o_pc), 32'(mq[0].pc1));
        end
        check("hlt", 32'(o_hlt), 32'(m_mode == 2));

        if (m_mode != 2) begin
            if (redir) begin
                mq.delete();
                m_pc   = rpc;
                m_mode = 0;
            end else begin
                if (e_valid && rdy) begin
                    e = mq.pop_front();
                    if (m_mode == 1 && e.word[15:12] == 4'hF) m_mode = 2;
                end
                if (e_req && ack) begin
                    nxt = m_pc + 16'd1;
                    mq.push_back('{word: imem_rdata, pc1: nxt});
                    if (imem_rdata[15:12] == 4'hF) m_mode = 1;
                    m_pc = nxt;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        imem_ack    = 1'b0;
        id_ready    = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 16'h1234;
        imem_rdata  = '0;
        #2;
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_hlt", 32'(hlt), 32'd0);
        redirect = 1'b0;
        mq.delete();
        m_pc   = '0;
        m_mode = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        @(negedge clk);

        // Streaming: sequential addresses, first valid two cycles after release.
        do_reset();
        step(1, 1, 0, '0);
        check("first_req_addr", 32'(o_addr), 32'h0);
        check("first_cycle_valid", 32'(o_valid), 32'd0);
        step(1, 1, 0, '0);
        check("second_cycle_valid", 32'(o_valid), 32'd1);
        check("second_cycle_pc", 32'(o_pc), 32'd1);
        repeat (8) step(1, 1, 0, '0);

        // Back-pressure: exactly DEPTH pushes, then one request per freed slot.
        do_reset();
        n = 0;
        repeat (8) begin
            step(1, 0, 0, '0);
            n += int'(o_req);
        end
        check("full_pushes", 32'(n), 32'(DEPTH));
        step(1, 1, 0, '0);
        n = int'(o_req);
        repeat (4) begin
            step(1, 0, 0, '0);
            n += int'(o_req);
        end
        check("refill_one", 32'(n), 32'd1);

        // Redirect flush with three entries queued.
        do_reset();
        repeat (3) step(1, 0, 0, '0);
        step(0, 0, 1, 16'h0040);
        step(1, 0, 0, '0);
        check("redir_valid", 32'(o_valid), 32'd0);
        check("redir_addr", 32'(o_addr), 32'h0040);
        repeat (4) step(1, 1, 0, '0);

        // Halt at 0x0005: no further requests, hlt after pop, redirect ignored.
        do_reset();
        halt_en   = 1'b1;
        halt_addr = 16'h0005;
        step(0, 0, 1, 16'h0005);
        step(1, 0, 0, '0);
        n = 0;
        repeat (3) begin
            step(1, 0, 0, '0);
            n += int'(o_req);
        end
        check("no_req_after_halt", 32'(n), 32'd0);
        step(1, 1, 0, '0);
        check("hlt_not_yet", 32'(o_hlt), 32'd0);
        step(1, 1, 0, '0);
        check("hlt_set", 32'(o_hlt), 32'd1);
        step(1, 1, 1, 16'h0030);
        check("hlt_redir_req", 32'(o_req), 32'd0);
        step(1, 1, 0, '0);
        check("hlt_sticky", 32'(o_hlt), 32'd1);

        // Halt queued behind older entries, squashed by redirect.
        do_reset();
        halt_addr = 16'h0002;
        repeat (4) step(1, 0, 0, '0);
        step(0, 1, 1, 16'h0010);
        step(1, 1, 0, '0);
        check("squash_addr", 32'(o_addr), 32'h0010);
        repeat (5) step(1, 1, 0, '0);
        check("squash_hlt", 32'(o_hlt), 32'd0);

        // Redirect coinciding with the halt pop wins.
        do_reset();
        halt_addr = 16'h0000;
        step(1, 0, 0, '0);
        step(0, 1, 1, 16'h0020);
        step(1, 1, 0, '0);
        check("coincide_hlt", 32'(o_hlt), 32'd0);
        check("coincide_addr", 32'(o_addr), 32'h0020);
        step(1, 1, 0, '0);
        halt_en = 1'b0;

        // PC wrap at 0xFFFF.
        do_reset();
        step(0, 0, 1, 16'hFFFF);
        step(1, 0, 0, '0);
        check("wrap_fetch_addr", 32'(o_addr), 32'hFFFF);
        step(0, 0, 0, '0);
        check("wrap_instr_pc", 32'(o_pc), 32'h0000);
        check("wrap_next_addr", 32'(o_addr), 32'h0000);

        // Randomized traffic, resetting mid-operation between rounds.
        use_rand = 1'b1;
        repeat (5) begin
            do_reset();
            repeat (400) begin
                step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6,
                     $urandom_range(0, 19) == 0, 16'($urandom));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fetch_buffer.md
FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, the number of queue entries (power of two, at least 2).
REQ-002 SHALL have parameter HALT_OP, default 4'hF, the opcode in instr[15:12] that denotes halt.
REQ-003 SHALL have port clk  input  1  the single clock; all state is updated on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port imem_req  output  1  fetch request to instruction memory.
REQ-006 SHALL have port imem_addr  output  16  word address of the request.
REQ-007 SHALL have port imem_ack  input  1  memory accepted the request; imem_rdata is valid in the same cycle.
REQ-008 SHALL have port imem_rdata  input  16  fetched instruction.
REQ-009 SHALL have port redirect  input  1  branch taken; flush the queue and refetch.
REQ-010 SHALL have port redirect_pc  input  16  target address, sampled when redirect=1.
REQ-011 SHALL have port id_ready  input  1  decode stage accepts the head entry.
REQ-012 SHALL have port instr_valid  output  1  head entry is valid.
REQ-013 SHALL have port instr  output  16  head instruction.
REQ-014 SHALL have port instr_pc  output  16  head instruction address plus 1 (the sequential PC).
REQ-015 SHALL have port hlt  output  1  processor halted.

Function
REQ-016 SHALL hold fetch_pc, a DEPTH-entry FIFO of {instr, addr+1}, a count in the range 0..DEPTH, and state in {FETCH, DRAIN, HALTED}.
REQ-017 SHALL assert imem_req = (state==FETCH) && (count<DEPTH) && !redirect, with imem_addr=fetch_pc.
REQ-018 On imem_req && imem_ack, SHALL push {imem_rdata, fetch_pc+1} and increment fetch_pc by 1, modulo 2^16 (wrapping 0xFFFF to 0x0000).
REQ-019 SHALL perform a pop when instr_valid && id_ready; push and pop in the same cycle leave count unchanged.
REQ-020 SHALL provide no bypass: a pushed entry becomes visible on instr_valid one cycle after its imem_ack.
REQ-021 SHALL drive instr_valid=(count!=0), with instr and instr_pc taken from the head; both are don't-care when instr_valid=0.
REQ-022 A push whose imem_rdata[15:12]==HALT_OP SHALL move state FETCH->DRAIN; no further requests are issued.
REQ-023 In DRAIN, when the halt entry is popped, SHALL move to HALTED and assert hlt from the next cycle.
REQ-024 Once hlt=1, SHALL stay HALTED: redirect, imem_ack and id_ready are ignored until reset.
REQ-025 On redirect in FETCH or DRAIN, SHALL within one cycle:
  - set count to 0;
  - set fetch_pc to redirect_pc;
  - set state to FETCH;
  - discard any pop that cycle;
  - issue no request that cycle (a speculatively fetched halt is squashed).
REQ-026 When redirect and a halt pop coincide, redirect SHALL win and hlt stays 0.
REQ-027 A queue overflow or underflow SHALL never occur; a pop while count==0 has no effect.

Reset
REQ-028 While rst_n=0, SHALL asynchronously set:
  - fetch_pc=0x0000;
  - count=0 and FIFO pointers=0;
  - state=FETCH;
  - hlt=0, imem_req=0, instr_valid=0.
REQ-029 Reset asserted mid-operation SHALL discard all queued entries; FIFO data storage need not be reset.
REQ-030 The first request SHALL be issued in the first cycle after rst_n rises, at address 0x0000.

Structure
REQ-031 A shared package cpu_pkg SHALL hold the state enum {FETCH, DRAIN, HALTED}, the HALT_OP default and the 16-bit word width constant.
REQ-032 SHALL instantiate one sub-module instr_fifo (32-bit entries, DEPTH deep, with push, pop, flush, count and head outputs); the FSM and PC logic stay in fetch_buffer.

Verification
REQ-033 Reset, then imem_ack=1 and id_ready=1 constantly -> addresses 0,1,2,... with instr_pc 1,2,3,... in order; first instr_valid occurs 2 cycles after reset release.
REQ-034 id_ready=0 with acks flowing -> exactly DEPTH (4) pushes, then imem_req=0; raising id_ready for one cycle -> exactly one new request.
REQ-035 Three entries queued, then redirect with redirect_pc=0x0040 -> next cycle instr_valid=0, and the next request is at 0x0040 with no old entries emerging.
REQ-036 Halt word 0xF000 fetched at 0x0005 -> no requests after it; hlt=1 in the cycle after it is popped; subsequent redirect leaves hlt=1.
REQ-037 Halt queued behind a branch, then redirect to 0x0010 before the halt pops -> hlt stays 0 and fetch resumes at 0x0010.
REQ-038 fetch_pc=0xFFFF fetched -> instr_pc=0x0000 and the next request is at 0x0000.
